// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-slave register bank.
package spi_reg_pkg;

    // Frame decoder phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    // Command bit values (first bit of every frame).
    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    // Frame length: command bit, address field, data field.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Frame bit counter for the SPI register bank. Counts sampled bits and flags
// the edge that captures the last bit of each frame phase. Cleared
// asynchronously by rst_n low or nCS high.
module spi_bit_counter
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic SCLK,
    input  logic rst_n,
    input  logic ncs_i,
    output logic cmd_done_o,
    output logic addr_done_o,
    output logic data_done_o
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clr_n;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign clr_n = rst_n & ~ncs_i;

    // Next count: saturate at FRAME_LEN so trailing bits cannot wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_W'(FRAME_LEN)) cnt_d = cnt_q + 1'b1;
    end

    // Count register, cleared by reset or frame end.
    always_ff @(posedge SCLK or negedge clr_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!clr_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Flags describe the bit being captured on the coming posedge.
    assign cmd_done_o  = (cnt_q == CNT_W'(0));
    assign addr_done_o = (cnt_q == CNT_W'(ADDR_W));
    assign data_done_o = (cnt_q == CNT_W'(ADDR_W + DATA_W));

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave (mode 0) register bank in the SCLK domain. Decodes
// {cmd, addr, data} frames MSB first and writes NUM_REGS registers.
// Optional readback on CIPO is enabled by defining SPI_READBACK_EN.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       SCLK,
    input  logic                       rst_n,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       addr_err
);

    logic              frame_rst_n;
    logic              cmd_done, addr_done, data_done;
    state_e            state_q, state_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_shift;
    logic [DATA_W-1:0] shift_q, shift_d, data_shift;
    logic [ADDR_W:0]   addr_ext;
    logic [DATA_W:0]   data_ext;
    logic              addr_ok;
    logic              addr_shift_en, data_shift_en, commit, err_set;
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              addr_err_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Frame-scoped state is cleared by reset or by nCS going high.
    assign frame_rst_n = rst_n & ~nCS;

    spi_bit_counter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bit_counter (
        .SCLK        (SCLK),
        .rst_n       (rst_n),
        .ncs_i       (nCS),
        .cmd_done_o  (cmd_done),
        .addr_done_o (addr_done),
        .data_done_o (data_done)
    );

    // Shifted field values including the bit on COPI right now.
    always_comb begin
        addr_ext   = {addr_q, COPI};
        data_ext   = {shift_q, COPI};
        addr_shift = addr_ext[ADDR_W-1:0];
        data_shift = data_ext[DATA_W-1:0];
        // Full-width compare: no aliasing of high addresses onto the bank.
        addr_ok    = ({1'b0, addr_shift} < (ADDR_W + 1)'(NUM_REGS));
    end

    // FSM state register plus frame datapath registers.
    always_ff @(posedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_WRITE;
            addr_q      <= '0;
            shift_q     <= '0;
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            wr_strobe_q <= commit;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_done) begin
`ifdef SPI_READBACK_EN
                state_d = ADDR;
`else
                state_d = (COPI == CMD_READ) ? DONE : ADDR;
`endif
            end
            ADDR: if (addr_done) state_d = addr_ok ? DATA : DONE;
            DATA: if (data_done) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: shift enables, commit and error set.
    always_comb begin
        cmd_d         = cmd_q;
        addr_shift_en = (state_q == ADDR);
        data_shift_en = (state_q == DATA) && (cmd_q == CMD_WRITE);
        commit        = data_shift_en && data_done;
        err_set       = addr_shift_en && addr_done && !addr_ok;
        if (state_q == IDLE && cmd_done) cmd_d = COPI;
        addr_d  = addr_shift_en ? addr_shift : addr_q;
        shift_d = data_shift_en ? data_shift : shift_q;
    end

    // Register array, write address and sticky error: only rst_n clears them.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register array is reset because downstream logic
            // relies on a known configuration out of reset.
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            wr_addr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (commit) begin
                for (int k = 0; k < NUM_REGS; k++)
                    if (addr_q == ADDR_W'(k)) regs_q[k] <= data_shift;
                wr_addr_q <= addr_q;
            end
            if (err_set) addr_err_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign addr_err  = addr_err_q;

`ifdef SPI_READBACK_EN
    logic              rd_load_q;
    logic              tx_oe_q;
    logic [DATA_W-1:0] tx_q, rd_word;
    logic [DATA_W:0]   tx_ext;

    // Read mux for the addressed register.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (addr_q == ADDR_W'(k)) rd_word = regs_q[k];
        tx_ext = {tx_q, 1'b0};
    end

    // Marks the posedge that accepted a valid read address.
    always_ff @(posedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) rd_load_q <= 1'b0;
        else rd_load_q <= addr_shift_en && addr_done && addr_ok && (cmd_q == CMD_READ);
    end

    // Falling-edge shifter: load on the first negedge, then shift MSB first.
    always_ff @(negedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            tx_q    <= '0;
            tx_oe_q <= 1'b0;
        end else if (rd_load_q) begin
            tx_q    <= rd_word;
            tx_oe_q <= 1'b1;
        end else if (tx_oe_q) begin
            tx_q    <= tx_ext[DATA_W-1:0];
        end
    end

    // Drive only during the data phase; entry to DONE releases the pad.
    always_comb begin
        cipo_oe = tx_oe_q && (state_q == DATA);
        CIPO    = cipo_oe && tx_q[DATA_W-1];
    end
`else
    assign CIPO    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank (default parameters).
// Readback checks follow SPI_READBACK_EN.
module tb_spi_reg_bank;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;

    logic                       SCLK;
    logic                       rst_n;
    logic                       nCS;
    logic                       COPI;
    logic                       CIPO;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       addr_err;

    int checks;
    int failures;

    logic [DATA_W-1:0] exp_regs [NUM_REGS];
    logic cipo_smp   [32];
    logic oe_smp     [32];
    logic strobe_smp [32];
    logic err_smp    [32];

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .SCLK      (SCLK),
        .rst_n     (rst_n),
        .nCS       (nCS),
        .COPI      (COPI),
        .CIPO      (CIPO),
        .cipo_oe   (cipo_oe),
        .regs      (regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .addr_err  (addr_err)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    function automatic logic [NUM_REGS*DATA_W-1:0] exp_image();
        logic [NUM_REGS*DATA_W-1:0] img;
        for (int k = 0; k < NUM_REGS; k++) img[k*DATA_W +: DATA_W] = exp_regs[k];
        return img;
    endfunction

    // Called at a negedge with nCS already low; returns at a negedge.
    task automatic shift_bits(input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            COPI = word[n-1-i];
            #4;
            cipo_smp[i] = CIPO;
            oe_smp[i]   = cipo_oe;
            @(posedge SCLK);
            #1;
            strobe_smp[i] = wr_strobe;
            err_smp[i]    = addr_err;
            @(negedge SCLK);
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int n);
        nCS = 1'b0;
        shift_bits(word, n);
    endtask

    task automatic end_frame();
        nCS  = 1'b1;
        COPI = 1'b0;
        @(negedge SCLK);
    endtask

    function automatic logic any_strobe(input int n);
        logic s = 1'b0;
        for (int i = 0; i < n; i++) s |= strobe_smp[i];
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge SCLK);
        checks++; if (regs !== '0) begin failures++; $display("FAIL reset_regs: got %h want 0", regs); end
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", addr_err); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        checks++; if (CIPO !== 1'b0) begin failures++; $display("FAIL reset_cipo: got %b want 0", CIPO); end
        checks++; if (cipo_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b want 0", cipo_oe); end
        rst_n = 1'b1;
        @(negedge SCLK);
    endtask

    task automatic test_write();
        send_frame(32'h82A5, 16);   // 1_0000010_10100101
        exp_regs[2] = 8'hA5;
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL write_regs: got %h want %h", regs, exp_image()); end
        checks++; if (wr_addr !== 7'd2) begin failures++; $display("FAIL write_wr_addr: got %h want 2", wr_addr); end
        checks++; if (strobe_smp[15] !== 1'b1) begin failures++; $display("FAIL write_strobe_set: got %b want 1", strobe_smp[15]); end
        checks++; if (any_strobe(15) !== 1'b0) begin failures++; $display("FAIL write_strobe_early: got 1 want 0"); end
        end_frame();
        checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL write_strobe_clr: got %b want 0", wr_strobe); end
    endtask

    task automatic test_addr_err();
        send_frame(32'h87FF, 16);   // write 0xFF to address 7
        checks++; if (err_smp[6] !== 1'b0) begin failures++; $display("FAIL err_early: got %b want 0", err_smp[6]); end
        checks++; if (err_smp[7] !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", err_smp[7]); end
        checks++; if (any_strobe(16) !== 1'b0) begin failures++; $display("FAIL err_strobe: got 1 want 0"); end
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL err_regs: got %h want %h", regs, exp_image()); end
        end_frame();
        checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", addr_err); end
        send_frame(32'hC277, 16);   // address 0x42 would alias to 2 if truncated
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL alias_regs: got %h want %h", regs, exp_image()); end
        checks++; if (any_strobe(16) !== 1'b0) begin failures++; $display("FAIL alias_strobe: got 1 want 0"); end
        checks++; if (wr_addr !== 7'd2) begin failures++; $display("FAIL alias_wr_addr: got %h want 2", wr_addr); end
        end_frame();
    endtask

    task automatic test_short_frame();
        send_frame(32'h81E, 12);    // first 12 bits of write 0xEE to address 1
        end_frame();
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL short_regs: got %h want %h", regs, exp_image()); end
        checks++; if (any_strobe(12) !== 1'b0) begin failures++; $display("FAIL short_strobe: got 1 want 0"); end
        send_frame(32'h843CF, 20);  // write 0x3C to address 4, then 4 extra ones
        exp_regs[4] = 8'h3C;
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL full_regs: got %h want %h", regs, exp_image()); end
        checks++; if (wr_addr !== 7'd4) begin failures++; $display("FAIL full_wr_addr: got %h want 4", wr_addr); end
        checks++; if (strobe_smp[15] !== 1'b1) begin failures++; $display("FAIL full_strobe_set: got %b want 1", strobe_smp[15]); end
        checks++; if (strobe_smp[16] !== 1'b0) begin failures++; $display("FAIL full_strobe_pulse: got %b want 0", strobe_smp[16]); end
        end_frame();
    endtask

    task automatic test_readback();
        logic [DATA_W-1:0] exp_word;
        exp_word = 8'h5A;
        send_frame(32'h815A, 16);   // write 0x5A to address 1
        end_frame();
        exp_regs[1] = 8'h5A;
        send_frame(32'h01FF, 16);   // read address 1, COPI held high in data phase
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL read_regs: got %h want %h", regs, exp_image()); end
`ifdef SPI_READBACK_EN
        checks++; if (oe_smp[7] !== 1'b0) begin failures++; $display("FAIL read_oe_early: got %b want 0", oe_smp[7]); end
        for (int i = 8; i < 16; i++) begin
            checks++;
            if (cipo_smp[i] !== exp_word[15-i] || oe_smp[i] !== 1'b1) begin
                failures++;
                $display("FAIL read_bit%0d: got cipo=%b oe=%b want cipo=%b oe=1", i + 1, cipo_smp[i], oe_smp[i], exp_word[15-i]);
            end
        end
`else
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cipo_smp[i] !== 1'b0 || oe_smp[i] !== 1'b0) begin
                failures++;
                $display("FAIL read_tied_bit%0d: got cipo=%b oe=%b want 0 0", i + 1, cipo_smp[i], oe_smp[i]);
            end
        end
`endif
        end_frame();
        checks++; if (cipo_oe !== 1'b0) begin failures++; $display("FAIL read_oe_end: got %b want 0", cipo_oe); end
        checks++; if (CIPO !== 1'b0) begin failures++; $display("FAIL read_cipo_end: got %b want 0", CIPO); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(32'h200, 10);    // first 10 bits of write 0x11 to address 0
        rst_n = 1'b0;
        @(negedge SCLK);
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
        checks++; if (regs !== '0) begin failures++; $display("FAIL midrst_regs: got %h want 0", regs); end
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL midrst_err: got %b want 0", addr_err); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL midrst_wr_addr: got %h want 0", wr_addr); end
        checks++; if (wr_strobe !== 1'b0 || cipo_oe !== 1'b0 || CIPO !== 1'b0) begin
            failures++; $display("FAIL midrst_outs: got strobe=%b oe=%b cipo=%b want 0 0 0", wr_strobe, cipo_oe, CIPO);
        end
        nCS   = 1'b1;
        rst_n = 1'b1;
        @(negedge SCLK);
        send_frame(32'h8011, 16);   // write 0x11 to address 0
        exp_regs[0] = 8'h11;
        checks++; if (regs !== exp_image()) begin failures++; $display("FAIL midrst_next_regs: got %h want %h", regs, exp_image()); end
        checks++; if (strobe_smp[15] !== 1'b1) begin failures++; $display("FAIL midrst_next_strobe: got %b want 1", strobe_smp[15]); end
        end_frame();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        nCS      = 1'b1;
        COPI     = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
        test_reset();
        test_write();
        test_addr_err();
        test_short_frame();
        test_readback();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
